// File: rtl/cw_seq_pkg.sv
// Shared constants, types and microinstruction layout for the control-word microsequencer.
// Microinstruction = {cond[2:0], br_addr[AW-1:0], cw[CW_W-1:0]}.
package cw_seq_pkg;

   localparam int CW_W       = 55;
   localparam int AW_DEFAULT = 5;

   localparam logic [2:0] COND_NEXT = 3'd0;
   localparam logic [2:0] COND_JMP  = 3'd1;
   localparam logic [2:0] COND_BZ   = 3'd2;
   localparam logic [2:0] COND_BN   = 3'd3;
   localparam logic [2:0] COND_BC   = 3'd4;
   localparam logic [2:0] COND_BV   = 3'd5;
   localparam logic [2:0] COND_BNZ  = 3'd6;
   localparam logic [2:0] COND_HALT = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   localparam int CW_LSB = 0;
   localparam int BR_LSB = CW_W;

   function automatic int cond_lsb(input int aw);
      return CW_W + aw;
   endfunction

   function automatic int ui_width(input int aw);
      return CW_W + aw + 3;
   endfunction

endpackage

// File: rtl/cw_microsequencer_if.sv
// Load/start/flag/control-word bundle between a controller (master) and the microsequencer (slave).
interface cw_microsequencer_if
   import cw_seq_pkg::*;
#(
   parameter int AW = AW_DEFAULT
);
   localparam int UI_W = ui_width(AW);

   logic            load_en;
   logic [AW-1:0]   load_addr;
   logic [UI_W-1:0] load_data;
   logic            start;
   logic [AW-1:0]   start_addr;
   logic            V;
   logic            C;
   logic            N;
   logic            Z;
   logic [CW_W-1:0] ControlWord;
   logic            cw_valid;
   logic [AW-1:0]   pc;
   logic            busy;
   logic            halted;

   modport master (
      output load_en, load_addr, load_data, start, start_addr, V, C, N, Z,
      input  ControlWord, cw_valid, pc, busy, halted
   );

   modport slave (
      input  load_en, load_addr, load_data, start, start_addr, V, C, N, Z,
      output ControlWord, cw_valid, pc, busy, halted
   );

endinterface

// File: rtl/cw_seq_cond.sv
// Branch-condition decode: microinstruction cond field plus status flags -> take_branch / is_halt.
module cw_seq_cond
   import cw_seq_pkg::*;
(
   input  logic [2:0] cond,
   input  logic       v,
   input  logic       c,
   input  logic       n,
   input  logic       z,
   output logic       take_branch,
   output logic       is_halt
);

   always_comb begin
      take_branch = 1'b0;
      is_halt     = 1'b0;
      case (cond)
         COND_JMP:  take_branch = 1'b1;
         COND_BZ:   take_branch = z;
         COND_BN:   take_branch = n;
         COND_BC:   take_branch = c;
         COND_BV:   take_branch = v;
         COND_BNZ:  take_branch = ~z;
         COND_HALT: is_halt     = 1'b1;
         default:   take_branch = 1'b0;
      endcase
   end

endmodule

// File: rtl/cw_microsequencer.sv
// Writable-microcode sequencer issuing one control word per clock with flag-conditional branching.
// Optional CW_SEQ_SINGLE_STEP_EN adds a step input that gates every RUN advance.
module cw_microsequencer
   import cw_seq_pkg::*;
#(
   parameter int AW = AW_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
`ifdef CW_SEQ_SINGLE_STEP_EN
   input  logic step,
`endif
   cw_microsequencer_if.slave bus
);

   localparam int UI_W     = ui_width(AW);
   localparam int COND_LSB = cond_lsb(AW);
   localparam int DEPTH    = 2**AW;

   // Read is combinational so a taken branch can be followed the very next cycle.
   logic [UI_W-1:0] mem [DEPTH];

   state_e          state_reg, state_next;
   logic [AW-1:0]   pc_reg, pc_next;
   logic [CW_W-1:0] cw_reg, cw_next;
   logic            valid_reg, valid_next;

   logic [UI_W-1:0] ui;
   logic [2:0]      ui_cond;
   logic [AW-1:0]   ui_br;
   logic [CW_W-1:0] ui_cw;
   logic            take_branch;
   logic            is_halt;
   logic            advance;

   assign ui      = mem[pc_reg];
   assign ui_cond = ui[COND_LSB +: 3];
   assign ui_br   = ui[BR_LSB +: AW];
   assign ui_cw   = ui[CW_LSB +: CW_W];

`ifdef CW_SEQ_SINGLE_STEP_EN
   assign advance = step;
`else
   assign advance = 1'b1;
`endif

   cw_seq_cond u_cond (
      .cond        (ui_cond),
      .v           (bus.V),
      .c           (bus.C),
      .n           (bus.N),
      .z           (bus.Z),
      .take_branch (take_branch),
      .is_halt     (is_halt)
   );

   // Writes only while stopped; memory is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (bus.load_en && (state_reg != RUN)) begin
         mem[bus.load_addr] <= bus.load_data;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      cw_next    = '0;
      valid_next = 1'b0;
      case (state_reg)
         IDLE, HALT: begin
            if (bus.start) begin
               state_next = RUN;
               pc_next    = bus.start_addr;
            end
         end
         RUN: begin
            if (advance) begin
               if (is_halt) begin
                  state_next = HALT;
               end else begin
                  cw_next    = ui_cw;
                  valid_next = 1'b1;
                  pc_next    = take_branch ? ui_br : pc_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         pc_reg    <= '0;
         cw_reg    <= '0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         cw_reg    <= cw_next;
         valid_reg <= valid_next;
      end
   end

   assign bus.ControlWord = cw_reg;
   assign bus.cw_valid    = valid_reg;
   assign bus.pc          = pc_reg;
   assign bus.busy        = (state_reg == RUN);
   assign bus.halted      = (state_reg == HALT);

endmodule

// File: tb/tb_cw_microsequencer.sv
// Scoreboard bench for cw_microsequencer: expected words are queued as programs start and popped each cycle.
module tb_cw_microsequencer;
   import cw_seq_pkg::*;

   localparam int AW   = 5;
   localparam int UI_W = CW_W + AW + 3;

   typedef struct packed {
      logic [CW_W-1:0] cw;
      logic            valid;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
`ifdef CW_SEQ_SINGLE_STEP_EN
   logic step = 1'b1;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   cw_microsequencer_if #(.AW(AW)) bus ();

   cw_microsequencer #(.AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef CW_SEQ_SINGLE_STEP_EN
      .step  (step),
`endif
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [UI_W-1:0] mk_ui(input logic [2:0] cond, input logic [AW-1:0] br,
                                             input logic [CW_W-1:0] cw);
      return {cond, br, cw};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [UI_W-1:0] d);
      bus.load_en   = 1'b1;
      bus.load_addr = a;
      bus.load_data = d;
      tick();
      bus.load_en   = 1'b0;
   endtask

   task automatic start_at(input logic [AW-1:0] a);
      bus.start      = 1'b1;
      bus.start_addr = a;
      tick();
      bus.start      = 1'b0;
   endtask

   task automatic push(input logic [CW_W-1:0] cw, input logic valid);
      exp_t e;
      e.cw    = cw;
      e.valid = valid;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
      bus.start = 1'b0; bus.start_addr = '0;
      bus.V = 1'b0; bus.C = 1'b0; bus.N = 1'b0; bus.Z = 1'b0;
      rst_n = 1'b0;
      repeat (2) tick();
      checks++;
      if (bus.ControlWord !== '0) begin errors++; $display("FAIL reset_cw: got %h required 0", bus.ControlWord); end
      checks++;
      if (bus.cw_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", bus.cw_valid); end
      checks++;
      if (bus.pc !== '0) begin errors++; $display("FAIL reset_pc: got %0d required 0", bus.pc); end
      checks++;
      if (bus.busy !== 1'b0 || bus.halted !== 1'b0) begin
         errors++; $display("FAIL reset_state: got busy=%b halted=%b required 0 0", bus.busy, bus.halted);
      end
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_linear();
      exp_t e;
      load(0, mk_ui(COND_NEXT, 0, 55'd1));
      load(1, mk_ui(COND_NEXT, 0, 55'd2));
      load(2, mk_ui(COND_NEXT, 0, 55'd3));
      load(3, mk_ui(COND_HALT, 0, 55'd0));
      push(55'd1, 1'b1); push(55'd2, 1'b1); push(55'd3, 1'b1); push('0, 1'b0);
      start_at(0);
      repeat (4) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (bus.ControlWord !== e.cw || bus.cw_valid !== e.valid) begin
            errors++;
            $display("FAIL linear_word: got cw=%h valid=%b required cw=%h valid=%b",
                     bus.ControlWord, bus.cw_valid, e.cw, e.valid);
         end
      end
      checks++;
      if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || bus.pc !== 5'd3) begin
         errors++;
         $display("FAIL linear_end: got halted=%b busy=%b pc=%0d required 1 0 3", bus.halted, bus.busy, bus.pc);
      end
   endtask

   task automatic test_branch();
      logic [2:0] conds [5];
      exp_t       e;
      logic       f;
      logic       taken;
      conds[0] = COND_BZ; conds[1] = COND_BN; conds[2] = COND_BC; conds[3] = COND_BV; conds[4] = COND_BNZ;
      for (int i = 0; i < 5; i++) begin
         for (int fv = 0; fv < 2; fv++) begin
            f = fv[0];
            load(0, mk_ui(conds[i], 5'd5, 55'h40 + 55'(i)));
            load(1, mk_ui(COND_JMP, 5'd7, 55'hA1));
            load(5, mk_ui(COND_JMP, 5'd7, 55'hA5));
            load(7, mk_ui(COND_HALT, 5'd0, 55'd0));
            // Non-tested flags carry the opposite value so a wrong flag select shows up.
            bus.V = ~f; bus.C = ~f; bus.N = ~f; bus.Z = ~f;
            case (conds[i])
               COND_BZ, COND_BNZ: bus.Z = f;
               COND_BN: bus.N = f;
               COND_BC: bus.C = f;
               default: bus.V = f;
            endcase
            taken = (conds[i] == COND_BNZ) ? ~f : f;
            push(55'h40 + 55'(i), 1'b1);
            push(taken ? 55'hA5 : 55'hA1, 1'b1);
            push('0, 1'b0);
            start_at(0);
            repeat (3) begin
               tick();
               e = exp_q.pop_front();
               checks++;
               if (bus.ControlWord !== e.cw || bus.cw_valid !== e.valid) begin
                  errors++;
                  $display("FAIL branch_c%0d_f%0d: got cw=%h valid=%b required cw=%h valid=%b",
                           conds[i], fv, bus.ControlWord, bus.cw_valid, e.cw, e.valid);
               end
            end
            checks++;
            if (bus.pc !== 5'd7 || bus.halted !== 1'b1) begin
               errors++;
               $display("FAIL branch_end_c%0d_f%0d: got pc=%0d halted=%b required 7 1",
                        conds[i], fv, bus.pc, bus.halted);
            end
         end
      end
      bus.V = 1'b0; bus.C = 1'b0; bus.N = 1'b0; bus.Z = 1'b0;
   endtask

   task automatic test_wrap();
      exp_t e;
      load(31, mk_ui(COND_NEXT, 0, 55'h31F));
      load(0, mk_ui(COND_HALT, 0, 55'd0));
      push(55'h31F, 1'b1); push('0, 1'b0);
      start_at(31);
      repeat (2) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (bus.ControlWord !== e.cw || bus.cw_valid !== e.valid) begin
            errors++;
            $display("FAIL wrap_word: got cw=%h valid=%b required cw=%h valid=%b",
                     bus.ControlWord, bus.cw_valid, e.cw, e.valid);
         end
      end
      checks++;
      if (bus.pc !== 5'd0 || bus.halted !== 1'b1) begin
         errors++; $display("FAIL wrap_end: got pc=%0d halted=%b required 0 1", bus.pc, bus.halted);
      end
   endtask

   task automatic test_load_during_run();
      exp_t e;
      load(0, mk_ui(COND_NEXT, 0, 55'h100));
      load(1, mk_ui(COND_NEXT, 0, 55'h101));
      load(2, mk_ui(COND_NEXT, 0, 55'h102));
      load(3, mk_ui(COND_HALT, 0, 55'd0));
      load(10, mk_ui(COND_NEXT, 0, 55'hEEE));
      push(55'h100, 1'b1); push(55'h101, 1'b1); push(55'h102, 1'b1); push('0, 1'b0);
      start_at(0);
      // Both the write and the restart request arrive while running and must be dropped.
      bus.load_en = 1'b1; bus.load_addr = 5'd2; bus.load_data = mk_ui(COND_NEXT, 0, 55'hBAD);
      bus.start = 1'b1; bus.start_addr = 5'd10;
      for (int k = 0; k < 4; k++) begin
         tick();
         bus.load_en = 1'b0;
         bus.start   = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if (bus.ControlWord !== e.cw || bus.cw_valid !== e.valid) begin
            errors++;
            $display("FAIL run_load_word%0d: got cw=%h valid=%b required cw=%h valid=%b",
                     k, bus.ControlWord, bus.cw_valid, e.cw, e.valid);
         end
      end
      push(55'h102, 1'b1); push('0, 1'b0);
      start_at(2);
      repeat (2) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (bus.ControlWord !== e.cw || bus.cw_valid !== e.valid) begin
            errors++;
            $display("FAIL run_load_refetch: got cw=%h valid=%b required cw=%h valid=%b",
                     bus.ControlWord, bus.cw_valid, e.cw, e.valid);
         end
      end
   endtask

   task automatic test_load_start_same();
      exp_t e;
      load(10, mk_ui(COND_HALT, 0, 55'd0));
      bus.load_en = 1'b1; bus.load_addr = 5'd9; bus.load_data = mk_ui(COND_NEXT, 0, 55'h999);
      bus.start = 1'b1; bus.start_addr = 5'd9;
      push(55'h999, 1'b1); push('0, 1'b0);
      tick();
      bus.load_en = 1'b0; bus.start = 1'b0;
      repeat (2) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (bus.ControlWord !== e.cw || bus.cw_valid !== e.valid) begin
            errors++;
            $display("FAIL load_start_word: got cw=%h valid=%b required cw=%h valid=%b",
                     bus.ControlWord, bus.cw_valid, e.cw, e.valid);
         end
      end
      checks++;
      if (bus.pc !== 5'd10) begin errors++; $display("FAIL load_start_pc: got %0d required 10", bus.pc); end
   endtask

`ifdef CW_SEQ_SINGLE_STEP_EN
   task automatic test_step();
      exp_t e;
      int   idx;
      load(0, mk_ui(COND_NEXT, 0, 55'h51));
      load(1, mk_ui(COND_NEXT, 0, 55'h52));
      load(2, mk_ui(COND_NEXT, 0, 55'h53));
      load(3, mk_ui(COND_HALT, 0, 55'd0));
      step = 1'b0;
      start_at(0);
      idx = 0;
      for (int c = 1; c <= 7; c++) begin
         step = (c == 2 || c == 5);
         if (step) begin push(55'h51 + 55'(idx), 1'b1); idx++; end
         else push('0, 1'b0);
         tick();
         e = exp_q.pop_front();
         checks++;
         if (bus.ControlWord !== e.cw || bus.cw_valid !== e.valid) begin
            errors++;
            $display("FAIL step_cycle%0d: got cw=%h valid=%b required cw=%h valid=%b",
                     c, bus.ControlWord, bus.cw_valid, e.cw, e.valid);
         end
      end
      checks++;
      if (bus.pc !== 5'd2 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL step_pc: got pc=%0d busy=%b required 2 1", bus.pc, bus.busy);
      end
      step = 1'b1;
      push(55'h53, 1'b1); push('0, 1'b0);
      repeat (2) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (bus.ControlWord !== e.cw || bus.cw_valid !== e.valid) begin
            errors++;
            $display("FAIL step_tail: got cw=%h valid=%b required cw=%h valid=%b",
                     bus.ControlWord, bus.cw_valid, e.cw, e.valid);
         end
      end
   endtask
`endif

   task automatic test_reset_midrun();
      exp_t e;
      load(0, mk_ui(COND_NEXT, 0, 55'd1));
      load(1, mk_ui(COND_NEXT, 0, 55'd2));
      load(2, mk_ui(COND_NEXT, 0, 55'd3));
      load(3, mk_ui(COND_HALT, 0, 55'd0));
      start_at(0);
      tick();
      checks++;
      if (bus.ControlWord !== 55'd1 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL midrun_first: got cw=%h busy=%b required 1 1", bus.ControlWord, bus.busy);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.ControlWord !== '0 || bus.cw_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pc !== '0) begin
         errors++;
         $display("FAIL midrun_reset: got cw=%h valid=%b busy=%b pc=%0d required 0 0 0 0",
                  bus.ControlWord, bus.cw_valid, bus.busy, bus.pc);
      end
      #2 rst_n = 1'b1;
      push(55'd1, 1'b1); push(55'd2, 1'b1); push(55'd3, 1'b1); push('0, 1'b0);
      start_at(0);
      repeat (4) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (bus.ControlWord !== e.cw || bus.cw_valid !== e.valid) begin
            errors++;
            $display("FAIL midrun_restart: got cw=%h valid=%b required cw=%h valid=%b",
                     bus.ControlWord, bus.cw_valid, e.cw, e.valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_linear();
      test_branch();
      test_wrap();
      test_load_during_run();
      test_load_start_same();
`ifdef CW_SEQ_SINGLE_STEP_EN
      test_step();
`endif
      test_reset_midrun();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "timeout");
   end

endmodule
